mem_fill_ctrl: RTL and testbench

- Upstream loader for the 32-byte pattern memory that the serial LED bit-reader scans.
- On a start request, writes all DEPTH locations in address order, using one of four selectable patterns, through a write port with ready backpressure.
- Reports busy, a one-cycle done pulse, and an 8-bit additive checksum of the bytes written, so the reader stage starts only on a fully loaded memory.

---
 rtl/mem_fill_ctrl.sv | 119 +++++++++++
 tb/tb_mem_fill_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fill_ctrl.sv
// Loads DEPTH pattern bytes in address order; first write one cycle after start, DEPTH+1 cycles to done.
// Holds address and data while wr_ready is low; no timeout.
module mem_fill_ctrl #(
    parameter int          DEPTH     = 32,
    parameter int          ADDR_W    = 5,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic              clock_50Mhz,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [7:0]        fill_value,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic [7:0]        checksum
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_mode;
    logic [7:0]  r_fill;
    logic [7:0]  r_lfsr;

    logic              w_accept;
    logic              w_last;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [7:0]        w_lfsr_nxt;
    logic [7:0]        w_pat_nxt;
    logic [7:0]        w_pat_first;

    function automatic logic [7:0] pattern(input logic [1:0]        m,
                                           input logic [7:0]        fv,
                                           input logic [ADDR_W-1:0] a,
                                           input logic [7:0]        lf);
        logic [7:0] idx;
        idx = 8'(a);
        case (m)
            2'd0:    pattern = idx;
            2'd1:    pattern = fv;
            2'd2:    pattern = lf;
            default: pattern = ~idx;
        endcase
    endfunction

    // Explicit last-address compare keeps the counter from wrapping inside WRITE.
    assign w_accept    = wr_en && wr_ready;
    assign w_last      = (wr_addr == ADDR_W'(DEPTH - 1));
    assign w_addr_nxt  = wr_addr + 1'b1;
    assign w_lfsr_nxt  = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_pat_nxt   = pattern(r_mode, r_fill, w_addr_nxt, w_lfsr_nxt);
    assign w_pat_first = pattern(mode, fill_value, '0, LFSR_SEED);

    always_ff @(posedge clock_50Mhz) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_mode   <= 2'd0;
            r_fill   <= 8'd0;
            r_lfsr   <= 8'd0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 8'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            checksum <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_mode   <= mode;
                        r_fill   <= fill_value;
                        r_lfsr   <= LFSR_SEED;
                        checksum <= 8'd0;
                        wr_addr  <= '0;
                        wr_data  <= w_pat_first;
                        wr_en    <= 1'b1;
                        busy     <= 1'b1;
                        r_state  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (w_accept) begin
                        checksum <= checksum + wr_data;
                        if (w_last) begin
                            wr_en   <= 1'b0;
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            wr_addr <= w_addr_nxt;
                            r_lfsr  <= w_lfsr_nxt;
                            wr_data <= w_pat_nxt;
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    wr_en   <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_fill_ctrl.sv
// Randomized bench for mem_fill_ctrl against a per-fill expected byte list and checksum.
module tb_mem_fill_ctrl;
    localparam int         DEPTH = 32;
    localparam int         AW    = 5;
    localparam logic [7:0] SEED  = 8'hA5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    mode;
    logic [7:0]    fill_value;
    logic          wr_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          busy;
    logic          done;
    logic [7:0]    checksum;

    always #5 clk = ~clk;

    mem_fill_ctrl #(.DEPTH(DEPTH), .ADDR_W(AW), .LFSR_SEED(SEED)) dut (
        .clock_50Mhz(clk), .reset(reset), .start(start), .mode(mode),
        .fill_value(fill_value), .wr_ready(wr_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
        .checksum(checksum)
    );

    int total = 0;
    int bad   = 0;

    int         cyc;
    int         done_cnt;
    int         done_at;
    int         first_wen;
    int         rdy_kind;
    int         rdy_phase;
    logic [7:0] cs_at_done;
    logic       busy_at_done;
    logic [7:0] obs_addr[$];
    logic [7:0] obs_data[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
        done_cnt  = 0;
        done_at   = -1;
        first_wen = -1;
    endtask

    // One clock: record any accept, advance, sample 1ns after the edge, pick next wr_ready.
    task automatic step();
        logic          stall;
        logic [AW-1:0] sa;
        logic [7:0]    sd;
        stall = wr_en && !wr_ready && reset;
        sa    = wr_addr;
        sd    = wr_data;
        if (wr_en && wr_ready) begin
            obs_addr.push_back(8'(wr_addr));
            obs_data.push_back(wr_data);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (stall) begin
            chk("stall_en", 32'(wr_en), 32'd1);
            chk("stall_addr", 32'(wr_addr), 32'(sa));
            chk("stall_data", 32'(wr_data), 32'(sd));
        end
        if (wr_en && first_wen < 0) first_wen = cyc;
        if (done) begin
            done_cnt++;
            done_at      = cyc;
            cs_at_done   = checksum;
            busy_at_done = busy;
        end
        case (rdy_kind)
            0: wr_ready = 1'b1;
            1: begin
                wr_ready = (rdy_phase % 4 == 0) || (rdy_phase % 4 == 3);
                rdy_phase++;
            end
            default: wr_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic build_model(input logic [1:0] m, input logic [7:0] fv,
                               output logic [7:0] ex[DEPTH], output logic [7:0] sum);
        logic [7:0] lf;
        lf  = SEED;
        sum = 8'd0;
        for (int i = 0; i < DEPTH; i++) begin
            case (m)
                2'd0:    ex[i] = 8'(i);
                2'd1:    ex[i] = fv;
                2'd2:    ex[i] = lf;
                default: ex[i] = 8'(255 - i);
            endcase
            sum = sum + ex[i];
            lf  = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
        end
    endtask

    task automatic check_writes(input logic [7:0] ex[DEPTH], input int base);
        for (int i = 0; i < DEPTH; i++) begin
            if (base + i < obs_addr.size()) begin
                chk($sformatf("addr%0d", i), 32'(obs_addr[base+i]), 32'(i));
                chk($sformatf("data%0d", i), 32'(obs_data[base+i]), 32'(ex[i]));
            end
        end
    endtask

    task automatic do_fill(input logic [1:0] m, input logic [7:0] fv, input int kind,
                           input bit poke_write, input bit poke_done);
        logic [7:0] ex[DEPTH];
        logic [7:0] sum;
        int lim;
        build_model(m, fv, ex, sum);
        clear_obs();
        rdy_kind   = kind;
        rdy_phase  = 0;
        mode       = m;
        fill_value = fv;
        start      = 1'b1;
        step();
        start      = 1'b0;
        mode       = 2'($urandom);
        fill_value = 8'($urandom);
        lim = 0;
        while (done_cnt == 0 && lim < 400) begin
            start = (poke_write && lim == 5);
            step();
            lim++;
        end
        chk("done_seen", 32'(done_cnt > 0), 32'd1);
        chk("cs_done", 32'(cs_at_done), 32'(sum));
        chk("busy_done", 32'(busy_at_done), 32'd1);
        if (kind == 0) chk("latency", 32'(done_at - first_wen), 32'(DEPTH));
        start = poke_done;
        step();
        start = 1'b0;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_wen", 32'(wr_en), 32'd0);
        step();
        chk("idle_wen2", 32'(wr_en), 32'd0);
        chk("cs_hold", 32'(checksum), 32'(sum));
        chk("done_cnt", 32'(done_cnt), 32'd1);
        chk("n_writes", 32'(obs_addr.size()), 32'(DEPTH));
        check_writes(ex, 0);
    endtask

    initial begin
        logic [7:0] ex[DEPTH];
        logic [7:0] sum;
        int lim;
        int d;
        cyc        = 0;
        rdy_kind   = 0;
        rdy_phase  = 0;
        reset      = 1'b0;
        start      = 1'b0;
        mode       = 2'd0;
        fill_value = 8'd0;
        wr_ready   = 1'b1;
        clear_obs();
        step();
        step();
        chk("rst_wen", 32'(wr_en), 32'd0);
        chk("rst_addr", 32'(wr_addr), 32'd0);
        chk("rst_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cs", 32'(checksum), 32'd0);
        reset = 1'b1;
        step();

        do_fill(2'd0, 8'h00, 0, 1'b0, 1'b0);
        do_fill(2'd1, 8'h03, 0, 1'b0, 1'b0);
        do_fill(2'd3, 8'h00, 0, 1'b0, 1'b0);
        do_fill(2'd2, 8'h00, 0, 1'b0, 1'b0);
        do_fill(2'd0, 8'h00, 1, 1'b0, 1'b0);
        do_fill(2'd2, 8'h5C, 2, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++)
            do_fill(2'($urandom), 8'($urandom), 2, 1'b0, 1'b0);

        // start held high: second fill begins after exactly one IDLE cycle
        build_model(2'd0, 8'h00, ex, sum);
        clear_obs();
        rdy_kind = 0;
        mode     = 2'd0;
        start    = 1'b1;
        step();
        lim = 0;
        while (done_cnt == 0 && lim < 200) begin step(); lim++; end
        chk("b2b_done1", 32'(done_cnt), 32'd1);
        d = done_at;
        step();
        chk("b2b_gap_wen", 32'(wr_en), 32'd0);
        chk("b2b_gap_busy", 32'(busy), 32'd0);
        step();
        chk("b2b_restart", 32'(wr_en), 32'd1);
        chk("b2b_cyc", 32'(cyc - d), 32'd2);
        start = 1'b0;
        lim = 0;
        while (done_cnt < 2 && lim < 200) begin step(); lim++; end
        chk("b2b_done2", 32'(done_cnt), 32'd2);
        chk("b2b_writes", 32'(obs_addr.size()), 32'(2 * DEPTH));
        check_writes(ex, DEPTH);
        step();
        step();

        // reset asserted mid-fill at address 10
        clear_obs();
        rdy_kind = 0;
        mode     = 2'd2;
        start    = 1'b1;
        step();
        start = 1'b0;
        lim = 0;
        while (!(wr_en && wr_addr == AW'(10)) && lim < 100) begin step(); lim++; end
        chk("mid_addr10", 32'(wr_addr), 32'd10);
        reset = 1'b0;
        step();
        chk("mid_wen", 32'(wr_en), 32'd0);
        chk("mid_addr", 32'(wr_addr), 32'd0);
        chk("mid_data", 32'(wr_data), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_cs", 32'(checksum), 32'd0);
        reset = 1'b1;
        step();
        step();
        chk("mid_nodone", 32'(done_cnt), 32'd0);
        chk("mid_idle", 32'(wr_en), 32'd0);
        do_fill(2'd2, 8'h00, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
